// File: rtl/lab71_usb_rst_seq_pkg.sv
// usb_rst_pkg: shared state encoding, status register offsets and status bit positions for the USB reset sequencer
package usb_rst_pkg;
  typedef enum logic [1:0] {ASSERT = 2'd0, RECOVER = 2'd1, READY = 2'd2} state_t;
  localparam logic [1:0] STAT_ADDR = 2'd0;
  localparam logic [1:0] CNT_ADDR  = 2'd1;
  localparam int RDY_BIT = 0;
  localparam int ST_LSB  = 1;
  localparam int REQ_BIT = 3;
endpackage

// File: rtl/lab71_usb_rst_seq_if.sv
// lab71_usb_rst_seq_if: read-only Avalon-MM status bus (address, chipselect in; readdata out of the slave)
interface lab71_usb_rst_seq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic [31:0] readdata;
  modport master (output address, chipselect, input readdata);
  modport slave (input address, chipselect, output readdata);
endinterface

// File: rtl/lab71_usb_rst_seq.sv
// lab71_usb_rst_seq: rst_req level -> min-width usb_rst_n pulse, recovery window, ready flag; status readable via bus (clk, reset_n, rst_req, bus, usb_rst_n, ready)
module lab71_usb_rst_seq
  import usb_rst_pkg::*;
#(
  parameter int MIN_ASSERT_CYCLES = 500,
  parameter int RECOVERY_CYCLES   = 2500,
  parameter int CNT_W             = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rst_req,
  lab71_usb_rst_seq_if.slave  bus,
  output logic                usb_rst_n,
  output logic                ready
);
  localparam logic [CNT_W-1:0] A_TERM = CNT_W'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_TERM = CNT_W'(RECOVERY_CYCLES - 1);
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       reset_count;
  logic             bump;
  logic             a_done, r_done;
  logic [31:0]      stat;
  assign a_done = cnt == A_TERM;
  assign r_done = cnt == R_TERM;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bump     = 1'b0;
    unique case (state)
      ASSERT: begin
        state_nx = (a_done && !rst_req) ? RECOVER : ASSERT;
        cnt_nx   = !a_done ? cnt + 1'b1 : rst_req ? cnt : '0;
      end
      RECOVER: begin
        state_nx = rst_req ? ASSERT : r_done ? READY : RECOVER;
        cnt_nx   = (rst_req || r_done) ? '0 : cnt + 1'b1;
        bump     = rst_req;
      end
      READY: begin
        state_nx = rst_req ? ASSERT : READY;
        cnt_nx   = '0;
        bump     = rst_req;
      end
      default: begin
        state_nx = ASSERT;
        cnt_nx   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ASSERT;
      cnt         <= '0;
      usb_rst_n   <= 1'b0;
      ready       <= 1'b0;
      reset_count <= 8'd0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      usb_rst_n   <= state_nx != ASSERT;
      ready       <= state_nx == READY;
      reset_count <= reset_count + 8'(bump);
    end
  end
  assign stat = (32'(ready) << RDY_BIT) | (32'(state) << ST_LSB) | (32'(rst_req) << REQ_BIT);
  assign bus.readdata = !bus.chipselect ? '0 :
                        bus.address == STAT_ADDR ? stat :
                        bus.address == CNT_ADDR ? {24'd0, reset_count} : '0;
endmodule

// File: tb/tb_lab71_usb_rst_seq.sv
// tb_lab71_usb_rst_seq: directed self-checking bench for the USB reset sequencer with MIN_ASSERT_CYCLES=4, RECOVERY_CYCLES=6
module tb_lab71_usb_rst_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rst_req = 1'b0;
  logic usb_rst_n, ready;
  int total = 0;
  int bad = 0;
  logic [31:0] rd_val;
  lab71_usb_rst_seq_if bus ();
  lab71_usb_rst_seq #(.MIN_ASSERT_CYCLES(4), .RECOVERY_CYCLES(6), .CNT_W(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rst_req(rst_req),
    .bus(bus),
    .usb_rst_n(usb_rst_n),
    .ready(ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [1:0] a, input logic cs);
    bus.address = a;
    bus.chipselect = cs;
    #1;
    rd_val = bus.readdata;
    bus.chipselect = 1'b0;
  endtask
  task automatic to_ready();
    rst_req = 1'b0;
    step(3);
    chk("low_hold", 32'(usb_rst_n), 0);
    step(1);
    chk("release", 32'(usb_rst_n), 1);
    step(5);
    chk("recov_not_ready", 32'(ready), 0);
    step(1);
    chk("ready_rise", 32'(ready), 1);
  endtask
  initial begin
    bus.address = 2'd0;
    bus.chipselect = 1'b0;
    step(3);
    chk("por_usb", 32'(usb_rst_n), 0);
    chk("por_ready", 32'(ready), 0);
    rd(2'd0, 1'b1);
    chk("por_stat", rd_val, 32'h0);
    reset_n = 1'b1;
    to_ready();
    rd(2'd1, 1'b1);
    chk("por_count", rd_val, 32'h0);
    rd(2'd0, 1'b1);
    chk("ready_stat", rd_val, 32'h5);
    rst_req = 1'b1;
    step(1);
    chk("pulse_usb_fall", 32'(usb_rst_n), 0);
    chk("pulse_ready_fall", 32'(ready), 0);
    rd(2'd0, 1'b1);
    chk("assert_stat", rd_val, 32'h8);
    to_ready();
    rd(2'd1, 1'b1);
    chk("pulse_count", rd_val, 32'h1);
    rst_req = 1'b1;
    step(20);
    chk("held_low", 32'(usb_rst_n), 0);
    rst_req = 1'b0;
    step(1);
    chk("held_release", 32'(usb_rst_n), 1);
    step(5);
    chk("held_not_ready", 32'(ready), 0);
    step(1);
    chk("held_ready", 32'(ready), 1);
    rst_req = 1'b1;
    step(1);
    rst_req = 1'b0;
    step(4);
    rd(2'd0, 1'b1);
    chk("recover_stat", rd_val, 32'h2);
    step(5);
    chk("term_not_ready", 32'(ready), 0);
    rst_req = 1'b1;
    step(1);
    chk("term_usb", 32'(usb_rst_n), 0);
    chk("term_ready", 32'(ready), 0);
    rst_req = 1'b0;
    step(3);
    chk("term_low", 32'(usb_rst_n), 0);
    step(1);
    chk("term_release", 32'(usb_rst_n), 1);
    rd(2'd1, 1'b1);
    chk("term_count", rd_val, 32'h4);
    for (int i = 0; i < 252; i++) begin
      step(2);
      rst_req = 1'b1;
      step(1);
      rst_req = 1'b0;
      step(2);
      if (i == 250) begin
        rd(2'd1, 1'b1);
        chk("count_255", rd_val, 32'hff);
      end
    end
    rd(2'd1, 1'b1);
    chk("count_wrap", rd_val, 32'h0);
    step(4);
    step(6);
    chk("wrap_ready", 32'(ready), 1);
    rd(2'd2, 1'b1);
    chk("addr2", rd_val, 32'h0);
    rd(2'd3, 1'b1);
    chk("addr3", rd_val, 32'h0);
    rd(2'd0, 1'b0);
    chk("nocs_addr0", rd_val, 32'h0);
    rst_req = 1'b1;
    step(1);
    rst_req = 1'b0;
    step(1);
    rd(2'd1, 1'b0);
    chk("nocs_addr1", rd_val, 32'h0);
    step(3);
    step(2);
    chk("pre_async_usb", 32'(usb_rst_n), 1);
    rd(2'd1, 1'b1);
    chk("pre_async_count", rd_val, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_usb", 32'(usb_rst_n), 0);
    chk("async_ready", 32'(ready), 0);
    rd(2'd0, 1'b1);
    chk("async_stat", rd_val, 32'h0);
    rd(2'd1, 1'b1);
    chk("async_count", rd_val, 32'h0);
    step(1);
    reset_n = 1'b1;
    to_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lab71_usb_rst_seq.md
# lab71_usb_rst_seq

Reset sequencer between the USB reset PIO bit and the MAX3421E `RES#` pin. It converts the software-controlled level from the PIO into a clean active-low chip reset with a guaranteed minimum assertion width and a post-release recovery window. It then reports readiness back to the CPU through a small read-only Avalon-MM status slave, so software polls `ready` instead of spinning on delay loops.

## Interface
Parameters:
- `MIN_ASSERT_CYCLES`, default 500: minimum `usb_rst_n` low time in clk cycles (10 µs at 50 MHz); must be ≥ 1.
- `RECOVERY_CYCLES`, default 2500: cycles after release before `ready` rises; must be ≥ 1.
- `CNT_W`, default 16: timer width; must hold max(MIN_ASSERT_CYCLES, RECOVERY_CYCLES) − 1.

Ports:
- `clk` in 1: system clock. One clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `rst_req` in 1: level from the USB reset PIO `out_port`; 1 requests chip reset.
- `address` in 2: status slave word address.
- `chipselect` in 1: status slave select.
- `readdata` out 32: status read data.
- `usb_rst_n` out 1: registered active-low reset to the USB chip.
- `ready` out 1: registered; 1 when the chip is out of reset and recovered.

## Operation
- States: ASSERT, RECOVER, READY. There is one shared timer `cnt[CNT_W-1:0]`.
- Reset values:
  - state = ASSERT, cnt = 0.
  - `usb_rst_n` = 0, `ready` = 0.
  - reset_count = 0.
  - The chip is therefore held in reset through power-on and gets a full minimum pulse afterwards.
- ASSERT:
  - `usb_rst_n` = 0, `ready` = 0.
  - cnt increments and saturates at MIN_ASSERT_CYCLES−1.
  - Go to RECOVER (cnt ← 0) when cnt == MIN_ASSERT_CYCLES−1 and `rst_req` == 0.
  - While `rst_req` stays 1, remain in ASSERT indefinitely.
- RECOVER:
  - `usb_rst_n` = 1, `ready` = 0.
  - cnt increments. When cnt == RECOVERY_CYCLES−1, go to READY.
  - `rst_req` == 1 has priority over completion: go to ASSERT, cnt ← 0.
- READY:
  - `usb_rst_n` = 1, `ready` = 1.
  - `rst_req` == 1 → ASSERT, cnt ← 0.
- `rst_req` is level-sensitive; no edge detection.
- reset_count (8 bit) increments on every ASSERT entry from RECOVER or READY. It does not increment on the `reset_n` entry, and it wraps 255 → 0.
- Status slave:
  - Read-only; writes are ignored.
  - `readdata` is combinational from address, with no waitrequest.
  - Address 0: bit0 = `ready`, bits[2:1] = state (ASSERT=0, RECOVER=1, READY=2), bit3 = `rst_req`, other bits 0.
  - Address 1: bits[7:0] = reset_count, other bits 0.
  - Addresses 2 and 3 read 0.
  - `readdata` is 0 when `chipselect` = 0.

## Timing
- All state, cnt, `usb_rst_n` and `ready` update on posedge `clk`. `usb_rst_n` and `ready` are decoded from registered next-state, so they change on the same edge as the state.
- `rst_req` rising while in READY at edge E: `usb_rst_n` falls and `ready` falls at E.
- If `rst_req` is already 0 on ASSERT entry, `usb_rst_n` is low for exactly MIN_ASSERT_CYCLES cycles.
- `ready` rises exactly RECOVERY_CYCLES cycles after `usb_rst_n` rises.
- Pulses of `rst_req` shorter than MIN_ASSERT_CYCLES still produce a full-width `usb_rst_n` pulse.
- `rst_req` reasserted in RECOVER on the same edge that cnt reaches terminal: ASSERT wins.
- `reset_n` asserted mid-operation forces the reset values immediately (asynchronously); `usb_rst_n` goes low without waiting for a clock edge.
- `readdata` is valid in the same cycle as `chipselect`/`address`, so read latency is 0.

## Structure
- Package `usb_rst_pkg`:
  - state typedef (2-bit enum ASSERT/RECOVER/READY with the encodings above).
  - status register offsets (`STAT_ADDR`=0, `CNT_ADDR`=1).
  - status bit positions.
- Single module. The timer is inline and no sub-module is warranted.

## Test plan
All scenarios use MIN_ASSERT_CYCLES=4, RECOVERY_CYCLES=6.
- Power-on: hold `reset_n` low for 3 cycles, then release with `rst_req`=0 → `usb_rst_n` low for 4 more cycles, `ready` high 6 cycles after `usb_rst_n` rises, reset_count = 0.
- From READY, 1-cycle `rst_req` pulse → `usb_rst_n` low for exactly 4 cycles, `ready` back after 6 more, address 1 reads 1.
- From READY, `rst_req` held for 20 cycles → `usb_rst_n` low for 20 cycles, releasing on the first edge after `rst_req` drops. Then `ready` follows 6 cycles later.
- `rst_req` pulse during RECOVER at cnt=5 (terminal) → returns to ASSERT with a full 4-cycle pulse, `ready` never rises, reset_count increments.
- 256 request pulses → reset_count wraps to 0. Reads at addresses 2 and 3, and reads with `chipselect`=0, return 0x00000000.
- `reset_n` asserted mid-RECOVER → `usb_rst_n`=0 and `ready`=0 immediately, without waiting for a clock edge, state reads 0, and reset_count clears.
